// File: rtl/alu_pkg.sv
// Shared ALU command encoding and default datapath width.
package alu_pkg;

  localparam int unsigned ALU_W_DEF = 3;
  localparam int unsigned CMD_W     = 3;

  // All eight codes are legal; the issue queue only transports them.
  typedef enum logic [CMD_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHR = 3'd6,
    ALU_SLT = 3'd7
  } alu_cmd_t;

endpackage

// File: rtl/op_fifo.sv
// Operation FIFO: DEPTH entries of DW bits, wrap-bit pointers, occupancy count.
module op_fifo #(
  parameter int unsigned DW    = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  // Full when indices match but wrap bits differ.
  assign count   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Pointer next-state; push and pop act on pre-edge occupancy.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers; reset empties the queue without clearing storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write at the write index.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: FIFO of operations feeding a registered issue stage to an
// external combinational ALU, with a registered result slot under backpressure.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [CMD_W-1:0]       in_cmd,
  output logic                   in_ready,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [CMD_W-1:0]       alu_cmd,
  input  logic [W-1:0]           alu_res,
  output logic                   res_valid,
  output logic [W-1:0]           res_data,
  output logic [CMD_W-1:0]       res_cmd,
  input  logic                   res_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned DW = 2*W + CMD_W;

  logic              full, empty, push, pop;
  logic [DW-1:0]     head;
  logic              slot_free, advance;

  logic              issue_v_q, issue_v_d;
  logic [W-1:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CMD_W-1:0]  alu_cmd_q, alu_cmd_d;
  logic              res_valid_q, res_valid_d;
  logic [W-1:0]      res_data_q, res_data_d;
  logic [CMD_W-1:0]  res_cmd_q, res_cmd_d;

  // Acceptance looks only at registered occupancy: no same-cycle pop bypass.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign slot_free = !res_valid_q || res_ready;
  assign advance   = !issue_v_q || slot_free;
  assign pop       = advance && !empty;

  op_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_a, in_b, in_cmd}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Issue and result stage next-state; a stalled result freezes both stages.
  always_comb begin
    issue_v_d   = issue_v_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cmd_d   = alu_cmd_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cmd_d   = res_cmd_q;
    if (advance) begin
      if (!empty) begin
        {alu_a_d, alu_b_d, alu_cmd_d} = head;
        issue_v_d = 1'b1;
      end else begin
        issue_v_d = 1'b0;   // operands keep their last values
      end
    end
    if (issue_v_q && slot_free) begin
      res_data_d  = alu_res;
      res_cmd_d   = alu_cmd_q;
      res_valid_d = 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Stage registers with synchronous reset discarding in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_v_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cmd_q   <= '0;
    end else begin
      issue_v_q   <= issue_v_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cmd_q   <= res_cmd_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cmd   = alu_cmd_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_cmd   = res_cmd_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench: accepted pushes queue their expected result, a negedge
// monitor pops and compares each consumed result; directed checks cover
// reset, latency, streaming, full, push/pop at count 3, stall and reset.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int unsigned W     = 3;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_a = '0, in_b = '0;
  logic [2:0]       in_cmd = '0;
  logic             in_ready;
  logic [W-1:0]     alu_a, alu_b, alu_res;
  logic [2:0]       alu_cmd;
  logic             res_valid;
  logic [W-1:0]     res_data;
  logic [2:0]       res_cmd;
  logic             res_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed { logic [2:0] cmd; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];
  int   n_vec = 0, n_fail = 0, n_pop = 0;

  always #5 clk = ~clk;

  // Reference ALU standing in for the external unit.
  function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a >> 1;
      default: return (a < b) ? W'(1) : W'(0);
    endcase
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_cmd);

  alu_issue_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_cmd(in_cmd), .in_ready(in_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cmd(alu_cmd), .alu_res(alu_res), .res_valid(res_valid),
    .res_data(res_data), .res_cmd(res_cmd), .res_ready(res_ready), .count(count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshakes seen at negedge complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back('{cmd: in_cmd, data: alu_f(in_a, in_b, in_cmd)});
      if (res_valid && res_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL spurious_result: got cmd %0d data %0d, none expected", res_cmd, res_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_cmd",  res_cmd,  e.cmd);
          chk("sb_data", res_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    in_valid = 1'b1; in_a = a; in_b = b; in_cmd = c;
    tick();
  endtask

  // Bounded drain, then everything must be empty and every result consumed.
  task automatic drain(input string name);
    in_valid = 1'b0; res_ready = 1'b1;
    repeat (DEPTH + 6) tick();
    chk({name, "_count"}, count, 0);
    chk({name, "_res_valid"}, res_valid, 0);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_in_ready"}, in_ready, 1);
    chk({name, "_count"}, count, 0);
    chk({name, "_res_valid"}, res_valid, 0);
    chk({name, "_alu"}, {alu_a, alu_b, alu_cmd}, 0);
    chk({name, "_res"}, {res_data, res_cmd}, 0);
  endtask

  initial begin
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    int pop0;

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    chk_reset("reset");

    // Single op latency
    res_ready = 1'b1;
    push_op(3'd4, 3'd5, 3'd0);
    in_valid = 1'b0;
    chk("single_e0_count", count, 1);
    chk("single_e0_rv", res_valid, 0);
    tick();
    chk("single_e1_alu", {alu_a, alu_b, alu_cmd}, {3'd4, 3'd5, 3'd0});
    chk("single_e1_rv", res_valid, 0);
    tick();
    chk("single_e2_rv", res_valid, 1);
    chk("single_e2_cmd", res_cmd, 0);
    chk("single_e2_data", res_data, 1);   // (4+5) mod 8
    drain("single");

    // Streaming: results on consecutive cycles in command order
    for (int i = 0; i < 8; i++) begin
      push_op(3'd4, 3'd5, 3'(i));
      if (i >= 2) begin
        chk("stream_rv", res_valid, 1);
        chk("stream_cmd", res_cmd, i - 2);
      end
    end
    in_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      tick();
      chk("stream_tail_rv", res_valid, 1);
      chk("stream_tail_cmd", res_cmd, i);
    end
    drain("stream");

    // Full: six accepted, extra pushes dropped, exactly six results
    res_ready = 1'b0;
    pop0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) chk("full_in_ready", in_ready, 0);
      push_op(3'($urandom), 3'($urandom), 3'(i));
    end
    chk("full_count", count, DEPTH);
    chk("full_in_ready_end", in_ready, 0);
    drain("full");
    chk("full_six_results", n_pop - pop0, 6);

    // Simultaneous push/pop at count 3
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(3'($urandom), 3'($urandom), 3'(i));
    chk("pp_count_before", count, 3);
    res_ready = 1'b1;
    push_op(3'd2, 3'd3, 3'd7);
    chk("pp_count_after", count, 3);
    drain("pp");

    // Stall: result and issue stage frozen under backpressure
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 3'($urandom); pb[i] = 3'($urandom);
      push_op(pa[i], pb[i], 3'(i + 1));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rv", res_valid, 1);
      chk("stall_res", {res_data, res_cmd}, {alu_f(pa[0], pb[0], 3'd1), 3'd1});
      chk("stall_alu", {alu_a, alu_b, alu_cmd}, {pa[1], pb[1], 3'd2});
      tick();
    end
    drain("stall");

    // Reset mid-stream: 3 queued, 1 issued, 1 unconsumed
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(3'($urandom), 3'($urandom), 3'(i));
    in_valid = 1'b0;
    chk("mid_count", count, 3);
    chk("mid_rv", res_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("mid_reset");
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", res_valid, 0);
    end

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 3'($urandom);
      in_b      = 3'($urandom);
      in_cmd    = 3'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
